vga_pixfifo: RTL and testbench

VGA_PIXFIFO -- requirements
Module: vga_pixfifo

---
 rtl/vga_pixfifo.sv | 136 +++++++++++++
 tb/tb_vga_pixfifo.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/vga_pixfifo.sv
// Pixel FIFO between an upstream pixel source and a VGA display controller.
// Entries carry {sof, pixel}. A small FSM keeps the display frame-aligned with
// the stream: it flushes until a start-of-frame entry is at the head, arms, and
// then locks on the controller's new-frame pulse. A frame that runs short, runs
// long, or underflows drops it back to FLUSH.
module vga_pixfifo #(
  parameter int                 BPC        = 4,
  parameter int                 LGFIFO     = 5,
  parameter logic [3*BPC-1:0]   FILL_COLOR = '0
) (
  input  logic                  i_pixclk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [3*BPC-1:0]      i_pixel,
  input  logic                  i_sof,
  input  logic                  i_rd,
  input  logic                  i_newframe,
  output logic [3*BPC-1:0]      o_pixel,
  output logic [LGFIFO:0]       o_fill,
  output logic                  o_locked,
  output logic                  o_underflow,
  output logic                  o_resync,
  output logic [15:0]           o_err_count
);

  localparam int PW = 3 * BPC;
  localparam int D  = 1 << LGFIFO;

  localparam logic [1:0] FLUSH  = 2'd0;
  localparam logic [1:0] ARMED  = 2'd1;
  localparam logic [1:0] ACTIVE = 2'd2;

  logic [PW:0]       mem [D];
  logic [LGFIFO-1:0] wr_ptr, rd_ptr;
  logic [LGFIFO:0]   fill, fill_nxt;
  logic              ready_q;
  logic [1:0]        state, state_nxt;
  logic              expect_sof, expect_nxt;
  logic [15:0]       err_count;

  logic [PW:0]       head;
  logic              head_sof, empty, wr, pop, rd_ok, underflow, resync;

  assign head     = mem[rd_ptr];
  assign head_sof = head[PW];
  assign empty    = (fill == '0);
  assign wr       = i_valid && ready_q;
  // Occupancy never exceeds D, so bit LGFIFO set means exactly full.
  assign fill_nxt = fill + (LGFIFO+1)'(wr) - (LGFIFO+1)'(pop);

  // Frame-alignment FSM: decides pops, pulses and the next state.
  always_comb begin
    state_nxt  = state;
    expect_nxt = expect_sof;
    pop        = 1'b0;
    rd_ok      = 1'b0;
    underflow  = 1'b0;
    resync     = 1'b0;
    case (state)
      FLUSH: begin
        if (!empty) begin
          if (head_sof) state_nxt = ARMED;
          else          pop       = 1'b1;
        end
      end
      ARMED: begin
        if (i_newframe) begin
          state_nxt  = ACTIVE;
          expect_nxt = 1'b1;
        end
      end
      ACTIVE: begin
        if (i_rd) begin
          if (empty) begin
            underflow = 1'b1;
            resync    = 1'b1;
            state_nxt = FLUSH;
          end else if (head_sof == expect_sof) begin
            pop        = 1'b1;
            rd_ok      = 1'b1;
            expect_nxt = 1'b0;
          end else begin
            resync    = 1'b1;
            state_nxt = FLUSH;
          end
        end
        // New-frame wins over the clear from a coincident pop; the pop itself
        // was already checked against the old flag above.
        if (i_newframe) expect_nxt = 1'b1;
      end
      default: state_nxt = FLUSH;
    endcase
    if (i_reset) begin
      pop    = 1'b0;
      rd_ok  = 1'b0;
      underflow = 1'b0;
      resync = 1'b0;
    end
  end

  // FIFO storage: written only when an upstream transfer is accepted.
  always_ff @(posedge i_pixclk) begin
    if (wr) mem[wr_ptr] <= {i_sof, i_pixel};
  end

  // Pointers, occupancy, registered ready, FSM state and error counter.
  always_ff @(posedge i_pixclk) begin
    if (i_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill       <= '0;
      ready_q    <= 1'b1;
      state      <= FLUSH;
      expect_sof <= 1'b0;
      err_count  <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fill       <= fill_nxt;
      ready_q    <= !fill_nxt[LGFIFO];
      state      <= state_nxt;
      expect_sof <= expect_nxt;
      if (resync && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end

  assign o_ready     = ready_q;
  assign o_fill      = fill;
  assign o_locked    = (state == ACTIVE);
  assign o_underflow = underflow;
  assign o_resync    = resync;
  assign o_err_count = err_count;
  assign o_pixel     = rd_ok ? head[PW-1:0] : FILL_COLOR;

endmodule

// File: tb/tb_vga_pixfifo.sv
// Directed bench for vga_pixfifo. Stimulus pushes the expected per-read
// response into a queue; a negedge monitor pops and compares on every i_rd
// cycle and checks idle outputs on every other cycle.
module tb_vga_pixfifo;
  localparam logic [11:0] FILL = 12'hABC;

  typedef struct {
    logic [11:0] pix;
    logic        uf;
    logic        rs;
  } exp_t;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1, i_valid = 1'b0, i_sof = 1'b0, i_rd = 1'b0, i_newframe = 1'b0;
  logic [11:0] i_pixel = '0;
  logic        o_ready, o_locked, o_underflow, o_resync;
  logic [11:0] o_pixel;
  logic [5:0]  o_fill;
  logic [15:0] o_err_count;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  vga_pixfifo #(.BPC(4), .LGFIFO(5), .FILL_COLOR(FILL)) dut (
    .i_pixclk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_pixel(i_pixel), .i_sof(i_sof), .i_rd(i_rd), .i_newframe(i_newframe),
    .o_pixel(o_pixel), .o_fill(o_fill), .o_locked(o_locked),
    .o_underflow(o_underflow), .o_resync(o_resync), .o_err_count(o_err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [11:0] pix, input logic uf, input logic rs);
    exp_t e;
    e.pix = pix; e.uf = uf; e.rs = rs;
    sb.push_back(e);
  endtask

  // Monitor: compare read-cycle responses against the scoreboard.
  always @(negedge clk) begin
    if (i_rd) begin
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL rd_unexpected: read with empty scoreboard, pixel %0h", o_pixel);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rd_pixel", 32'(o_pixel), 32'(e.pix));
        chk("rd_flags", {30'd0, o_underflow, o_resync}, {30'd0, e.uf, e.rs});
      end
    end else begin
      chk("idle_out", {19'd0, o_underflow, o_resync, o_pixel}, {19'd0, 1'b0, 1'b0, FILL});
    end
  end

  initial begin
    // Reset
    tick(); tick();
    i_reset = 1'b0;
    chk("rst_fill", 32'(o_fill), 0);
    chk("rst_locked", 32'(o_locked), 0);
    chk("rst_ready", 32'(o_ready), 1);
    chk("rst_err", 32'(o_err_count), 0);

    // Basic frame: 4 pixels, sof on first
    for (int i = 0; i < 4; i++) begin
      i_valid = 1'b1; i_sof = (i == 0); i_pixel = 12'h111 * 12'(i + 1);
      tick();
    end
    i_valid = 1'b0; i_sof = 1'b0;
    chk("t1_fill4", 32'(o_fill), 4);
    chk("t1_prelock", 32'(o_locked), 0);
    i_newframe = 1'b1; tick(); i_newframe = 1'b0;
    chk("t1_locked", 32'(o_locked), 1);
    for (int i = 0; i < 4; i++) begin
      i_rd = 1'b1; push(12'h111 * 12'(i + 1), 1'b0, 1'b0);
      tick();
    end
    i_rd = 1'b0;
    chk("t1_err", 32'(o_err_count), 0);
    chk("t1_fill0", 32'(o_fill), 0);

    // Underflow while ACTIVE
    i_rd = 1'b1; push(FILL, 1'b1, 1'b1); tick(); i_rd = 1'b0;
    chk("uf_locked", 32'(o_locked), 0);
    chk("uf_err", 32'(o_err_count), 1);

    // FLUSH: 5 non-sof then sof
    for (int i = 0; i < 6; i++) begin
      i_valid = 1'b1; i_sof = (i == 5); i_pixel = 12'h500 + 12'(i);
      tick();
    end
    i_valid = 1'b0; i_sof = 1'b0;
    chk("fl_fill1", 32'(o_fill), 1);
    tick();
    chk("fl_armed_fill", 32'(o_fill), 1);
    chk("fl_not_locked", 32'(o_locked), 0);
    i_newframe = 1'b1; tick(); i_newframe = 1'b0;
    chk("fl_locked", 32'(o_locked), 1);
    i_rd = 1'b1; push(12'h505, 1'b0, 1'b0); tick(); i_rd = 1'b0;

    // Frame too long: sof arrives while expect_sof = 0
    for (int i = 1; i <= 4; i++) begin
      i_valid = 1'b1; i_sof = (i == 4); i_pixel = 12'h600 + 12'(i);
      tick();
    end
    i_valid = 1'b0; i_sof = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      i_rd = 1'b1; push(12'h600 + 12'(i), 1'b0, 1'b0); tick();
    end
    push(FILL, 1'b0, 1'b1); tick(); i_rd = 1'b0;
    chk("long_locked", 32'(o_locked), 0);
    chk("long_fill", 32'(o_fill), 1);
    chk("long_err", 32'(o_err_count), 2);
    tick();
    chk("long_retained", 32'(o_fill), 1);
    i_newframe = 1'b1; tick(); i_newframe = 1'b0;
    chk("long_relock", 32'(o_locked), 1);
    i_rd = 1'b1; push(12'h604, 1'b0, 1'b0); tick(); i_rd = 1'b0;

    // Read coincident with newframe uses old expect_sof, then short frame
    i_valid = 1'b1; i_pixel = 12'h701; tick(); i_valid = 1'b0;
    i_rd = 1'b1; i_newframe = 1'b1; push(12'h701, 1'b0, 1'b0); tick();
    i_rd = 1'b0; i_newframe = 1'b0;
    i_valid = 1'b1; i_pixel = 12'h702; tick(); i_valid = 1'b0;
    i_rd = 1'b1; push(FILL, 1'b0, 1'b1); tick(); i_rd = 1'b0;
    chk("nf_err", 32'(o_err_count), 3);
    chk("nf_locked", 32'(o_locked), 0);
    tick(); tick();
    chk("nf_flushed", 32'(o_fill), 0);

    // Full FIFO
    for (int i = 0; i < 32; i++) begin
      i_valid = 1'b1; i_sof = (i == 0); i_pixel = 12'h800 + 12'(i);
      tick();
    end
    i_valid = 1'b0; i_sof = 1'b0;
    chk("full_fill", 32'(o_fill), 32);
    chk("full_ready", 32'(o_ready), 0);
    i_valid = 1'b1; i_pixel = 12'hFFF; tick(); i_valid = 1'b0;
    chk("full_nowrite", 32'(o_fill), 32);
    i_newframe = 1'b1; tick(); i_newframe = 1'b0;
    chk("full_locked", 32'(o_locked), 1);
    i_rd = 1'b1; push(12'h800, 1'b0, 1'b0); tick(); i_rd = 1'b0;
    chk("full_ready_back", 32'(o_ready), 1);
    chk("full_fill31", 32'(o_fill), 31);

    // Reset while ACTIVE with 10 entries
    for (int i = 1; i <= 21; i++) begin
      i_rd = 1'b1; push(12'h800 + 12'(i), 1'b0, 1'b0); tick();
    end
    i_rd = 1'b0;
    chk("pre_rst_fill", 32'(o_fill), 10);
    chk("pre_rst_locked", 32'(o_locked), 1);
    i_reset = 1'b1; tick(); i_reset = 1'b0;
    chk("mid_rst_fill", 32'(o_fill), 0);
    chk("mid_rst_locked", 32'(o_locked), 0);
    chk("mid_rst_err", 32'(o_err_count), 0);
    chk("mid_rst_ready", 32'(o_ready), 1);
    tick();
    chk("sb_drained", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
